seg7_scan_display: RTL and testbench

//  Parametrised, time-multiplexed N-digit hex seven-segment driver for FPGA test tops.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_display_if.sv | 25 ++
 rtl/seg7_hex_decoder.sv | 10 +
 rtl/seg7_scan_display.sv | 133 +++++++++++++
 tb/tb_seg7_scan_display.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
// Segment codes here are active-high ({g,f,e,d,c,b,a}); polarity is applied at the pins.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex2seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Value capture and display pin bundle for seg7_scan_display.
// The master side drives the value and controls; the slave side drives the display pins.
interface seg7_scan_display_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIGITS = 4
);
    logic [DATA_WIDTH-1:0] value_in;
    logic                  value_valid;
    logic                  hold;
    logic                  blank_lz;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_tick;

    modport master (
        output value_in, value_valid, hold, blank_lz,
        input  seg_n, dp_n, digit_sel, frame_tick
    );

    modport slave (
        input  value_in, value_valid, hold, blank_lz,
        output seg_n, dp_n, digit_sel, frame_tick
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high segment pattern.
// Zero latency; no flow control.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);
    assign seg = hex2seg(nibble);
endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit hex seven-segment driver with tear-free frame updates.
// Latency: pins are registered, one cycle behind the scan counters; value shows from the next frame.
// Backpressure: none; value_valid is a strobe, last strobe before frame end wins, hold ignores it.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 16,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_display_if.slave bus
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int EXT_W  = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_INV = DIGIT_ACTIVE_LOW ? '1 : '0;

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [DATA_WIDTH-1:0] pending;
    logic [DATA_WIDTH-1:0] shown;
    logic [EXT_W-1:0]      shown_ext;
    logic                  ovf;
    logic                  slot_last;
    logic                  idx_last;
    logic                  frame_end;
    logic                  capture;

    assign slot_last = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign idx_last  = (scan_idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end = slot_last && idx_last;
    assign capture   = bus.value_valid && !bus.hold;

    assign bus.frame_tick = frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            scan_idx <= idx_last ? '0 : scan_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // A strobe landing on the frame_end cycle goes straight to shown so it is not lost for a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            shown   <= '0;
        end else begin
            if (capture) begin
                pending <= bus.value_in;
            end
            if (frame_end) begin
                shown <= capture ? bus.value_in : pending;
            end
        end
    end

    generate
        if (DATA_WIDTH > EXT_W) begin : g_wide
            assign shown_ext = shown[EXT_W-1:0];
            assign ovf       = |shown[DATA_WIDTH-1:EXT_W];
        end else if (DATA_WIDTH == EXT_W) begin : g_exact
            assign shown_ext = shown;
            assign ovf       = 1'b0;
        end else begin : g_narrow
            assign shown_ext = {{(EXT_W - DATA_WIDTH){1'b0}}, shown};
            assign ovf       = 1'b0;
        end
    endgenerate

    logic [3:0] cur_nib;
    seg_t       dec_seg;
    logic       upper_zero;
    logic       lz_blank;

    assign cur_nib = shown_ext[{scan_idx, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(scan_idx) && shown_ext[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign lz_blank = bus.blank_lz && upper_zero && (scan_idx != '0);

    seg_t                  seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] dig_on;

    always_comb begin
        seg_on = lz_blank ? SEG_OFF : dec_seg;
        dp_on  = ovf && idx_last;
        dig_on = '0;
        if (slot_cnt >= SLOT_W'(BLANK_CYCLES) && !lz_blank) begin
            dig_on = NUM_DIGITS'(1) << scan_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_n     <= SEG_INV;
            bus.dp_n      <= DP_INV;
            bus.digit_sel <= DIG_INV;
        end else begin
            bus.seg_n     <= seg_on ^ SEG_INV;
            bus.dp_n      <= dp_on ^ DP_INV;
            bus.digit_sel <= dig_on ^ DIG_INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4, BLANK_CYCLES=1, four digits.
module tb_seg7_scan_display;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_display_if #(.DATA_WIDTH(32), .NUM_DIGITS(4)) bus ();

    seg7_scan_display #(
        .DATA_WIDTH       (32),
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .BLANK_CYCLES     (1),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [31:0] v);
        bus.value_in    = v;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
    endtask

    // Leaves the bench one cycle after a frame_tick, so outputs next show slot 0 of digit 0.
    task automatic sync_frame();
        int n = 0;
        while (bus.frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tick_wait", {31'd0, bus.frame_tick}, 32'd1);
        @(negedge clk);
    endtask

    // segs packed {digit3, digit2, digit1, digit0}; mask = digits expected enabled.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] mask, input logic dp3);
        for (int j = 0; j < 16; j++) begin
            int         idx;
            int         slot;
            logic [3:0] ed;
            @(negedge clk);
            idx  = j / 4;
            slot = j % 4;
            ed   = (slot == 0 || !mask[idx]) ? 4'hF : ~(4'b0001 << idx);
            chk({tag, "_seg"},  {25'd0, bus.seg_n}, {25'd0, segs[idx*7 +: 7]});
            chk({tag, "_dig"},  {28'd0, bus.digit_sel}, {28'd0, ed});
            chk({tag, "_dp"},   {31'd0, bus.dp_n}, {31'd0, !(dp3 && idx == 3)});
            chk({tag, "_tick"}, {31'd0, bus.frame_tick}, {31'd0, j == 14});
        end
    endtask

    task automatic release_and_count();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            chk("first_tick", {31'd0, bus.frame_tick}, {31'd0, n == 15});
        end
    endtask

    initial begin
        bus.value_in    = '0;
        bus.value_valid = 1'b0;
        bus.hold        = 1'b0;
        bus.blank_lz    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg",  {25'd0, bus.seg_n}, 32'h7F);
        chk("rst_dig",  {28'd0, bus.digit_sel}, 32'hF);
        chk("rst_dp",   {31'd0, bus.dp_n}, 32'd1);
        chk("rst_tick", {31'd0, bus.frame_tick}, 32'd0);

        // Release: tick on the 16th cycle, "0000" with only digit 0 lit
        release_and_count();
        @(negedge clk);
        check_frame("zero_lz", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 1'b0);

        // Mid-frame value, display held until the frame boundary
        bus.blank_lz = 1'b0;
        repeat (5) @(negedge clk);
        pulse(32'h0000_1E5A);
        repeat (3) begin
            @(negedge clk);
            chk("no_tear", {25'd0, bus.seg_n}, 32'h40);
        end
        sync_frame();
        check_frame("v1e5a", {7'h79, 7'h06, 7'h12, 7'h08}, 4'hF, 1'b0);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        pulse(32'h0000_0005);
        sync_frame();
        check_frame("lz5", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0001, 1'b0);

        // Overflow indicator on the top digit
        bus.blank_lz = 1'b0;
        pulse(32'h0001_0000);
        sync_frame();
        check_frame("ovf", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b1);

        // Hold ignores strobes across several frames
        bus.hold = 1'b1;
        pulse(32'h0000_FFFF);
        for (int f = 0; f < 3; f++) begin
            sync_frame();
            check_frame("hold", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b1);
        end
        bus.hold = 1'b0;
        pulse(32'h0000_ABCD);
        sync_frame();
        check_frame("unhold", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 1'b0);

        // Hold raised after a capture: pending value still lands
        pulse(32'h0000_0002);
        bus.hold = 1'b1;
        pulse(32'h0000_FFFF);
        sync_frame();
        check_frame("hold_pend", {7'h40, 7'h40, 7'h40, 7'h24}, 4'hF, 1'b0);
        bus.hold = 1'b0;

        // Strobe on the frame_tick cycle is forwarded straight into the display
        begin
            int n = 0;
            while (bus.frame_tick !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("fwd_tick", {31'd0, bus.frame_tick}, 32'd1);
        end
        pulse(32'h0000_0007);
        check_frame("fwd", {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF, 1'b0);

        // Asynchronous reset mid-slot, then counting restarts from slot 0
        repeat (6) @(negedge clk);
        chk("pre_rst_dig", {28'd0, bus.digit_sel}, 32'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg",  {25'd0, bus.seg_n}, 32'h7F);
        chk("arst_dig",  {28'd0, bus.digit_sel}, 32'hF);
        chk("arst_dp",   {31'd0, bus.dp_n}, 32'd1);
        chk("arst_tick", {31'd0, bus.frame_tick}, 32'd0);
        release_and_count();
        @(negedge clk);
        check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
